// File: rtl/mos6502_bus_slave.sv
// Bus responder for the 6502 core: 32 KiB internal RAM, handshaked external ROM
// with wait-states and timeout, and a one-page I/O block with an IRQ countdown timer.
module mos6502_bus_slave #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        clk_en,
  input  logic [15:0] Address_bus,
  input  logic        RnW,
  input  logic [7:0]  Data_in,
  output logic [7:0]  Data_out,
  output logic        Data_oe,
  output logic        READY,
  output logic        nIRQ,
  output logic [14:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [1:0]  rom_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } rom_state_t;

  rom_state_t state;

  logic [7:0] ram [0:32767];

  logic       ram_sel;
  logic       io_sel;
  logic       rom_sel;
  logic       cyc_start;
  logic [7:0] to_cnt;
  logic       rom_timeout;
  logic [7:0] io_rdata;

  logic [1:0] ctrl, ctrl_n;
  logic [7:0] reload, reload_n;
  logic [7:0] count, count_n;
  logic       irq_flag, irq_n;
  logic       rom_err, err_n;

  assign ram_sel     = ~Address_bus[15];
  assign io_sel      = (Address_bus[15:8] == 8'hFE);
  assign rom_sel     = Address_bus[15] & ~io_sel;
  assign rom_timeout = (state == REQ) && !rom_ack && (to_cnt == 8'(TIMEOUT - 1));
  assign Data_oe     = RnW;
  assign rom_state   = state;

  always_comb begin
    io_rdata = 8'hFF;
    case (Address_bus[7:0])
      8'h00:   io_rdata = {irq_flag, rom_err, 4'b0000, ctrl};
      8'h01:   io_rdata = count;
      default: io_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en && !RnW && ram_sel)
      ram[Address_bus[14:0]] <= Data_in;
  end

  // ROM handshake FSM; it also owns Data_out so a ROM answer is held in DONE.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state     <= IDLE;
      rom_req   <= 1'b0;
      rom_addr  <= 15'd0;
      READY     <= 1'b1;
      to_cnt    <= 8'd0;
      cyc_start <= 1'b0;
      Data_out  <= 8'h00;
    end else begin
      cyc_start <= clk_en;
      case (state)
        IDLE: begin
          if (cyc_start && rom_sel && RnW) begin
            state    <= REQ;
            rom_req  <= 1'b1;
            rom_addr <= Address_bus[14:0];
            READY    <= 1'b0;
            to_cnt   <= 8'd0;
          end
          if (ram_sel)
            Data_out <= ram[Address_bus[14:0]];
          else if (io_sel)
            Data_out <= io_rdata;
        end
        REQ: begin
          if (rom_ack || rom_timeout) begin
            state    <= DONE;
            rom_req  <= 1'b0;
            rom_addr <= 15'd0;
            READY    <= 1'b1;
            Data_out <= rom_ack ? rom_data : 8'hFF;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          if (clk_en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next-state for the I/O block; clears are applied before sets so a set wins.
  always_comb begin
    ctrl_n   = ctrl;
    reload_n = reload;
    count_n  = count;
    irq_n    = irq_flag;
    err_n    = rom_err;
    if (clk_en) begin
      if (ctrl[0])
        count_n = (count == 8'd0) ? reload : count - 8'd1;
      if (io_sel && !RnW) begin
        if (Address_bus[7:0] == 8'h00) begin
          ctrl_n = Data_in[1:0];
          if (Data_in[7]) irq_n = 1'b0;
          if (Data_in[6]) err_n = 1'b0;
        end else if (Address_bus[7:0] == 8'h01) begin
          reload_n = Data_in;
          count_n  = Data_in;
        end
      end
      if (io_sel && RnW && (Address_bus[7:0] == 8'h00))
        irq_n = 1'b0;
      if (ctrl[0] && (count == 8'd0))
        irq_n = 1'b1;
    end
    if (rom_timeout)
      err_n = 1'b1;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ctrl     <= 2'b00;
      reload   <= 8'h00;
      count    <= 8'h00;
      irq_flag <= 1'b0;
      rom_err  <= 1'b0;
      nIRQ     <= 1'b1;
    end else begin
      ctrl     <= ctrl_n;
      reload   <= reload_n;
      count    <= count_n;
      irq_flag <= irq_n;
      rom_err  <= err_n;
      nIRQ     <= ~(irq_n & ctrl_n[1]);
    end
  end

endmodule

// File: tb/tb_mos6502_bus_slave.sv
// Directed bench for mos6502_bus_slave: RAM, ROM handshake/wait-states/timeout,
// I/O timer and IRQ, and asynchronous reset during a ROM request.
module tb_mos6502_bus_slave;

  logic        clk;
  logic        nRESET;
  logic        clk_en;
  logic [15:0] Address_bus;
  logic        RnW;
  logic [7:0]  Data_in;
  logic [7:0]  Data_out;
  logic        Data_oe;
  logic        READY;
  logic        nIRQ;
  logic [14:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [1:0]  rom_state;

  int n_checks = 0;
  int n_errors = 0;
  int ph;
  int ack_delay = 0;
  int req_age;
  logic [7:0] ack_data = 8'h00;
  logic       force_ack = 1'b0;

  logic [7:0] rd;
  logic       rdy;
  int         waits;

  mos6502_bus_slave #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .nRESET      (nRESET),
    .clk_en      (clk_en),
    .Address_bus (Address_bus),
    .RnW         (RnW),
    .Data_in     (Data_in),
    .Data_out    (Data_out),
    .Data_oe     (Data_oe),
    .READY       (READY),
    .nIRQ        (nIRQ),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .rom_state   (rom_state)
  );

  // clock / reset / cycle strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    clk_en = 1'b0;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph == 15) ? 0 : ph + 1;
      clk_en = (ph == 15);
    end
  end

  // ROM model: acks ack_delay clocks after rom_req rises (0 = never)
  initial begin
    rom_ack = 1'b0;
    rom_data = 8'h00;
    req_age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rom_req === 1'b1) req_age++;
      else req_age = 0;
      if ((ack_delay != 0 && rom_req === 1'b1 && req_age == ack_delay) || force_ack) begin
        rom_ack = 1'b1;
        rom_data = ack_data;
      end else begin
        rom_ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: a cycle starts just after a clk_en edge
  task automatic start_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] wd);
    @(negedge clk);
    Address_bus = a;
    RnW = rnw;
    Data_in = wd;
  endtask

  task automatic finish_cycle(output logic [7:0] rdata, output logic rready);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (clk_en !== 1'b1 && guard < 40);
    if (clk_en !== 1'b1) check("ce_wait", 16'd1, 16'd0);
    rdata = Data_out;
    rready = READY;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                           output logic [7:0] rdata, output logic rready);
    start_cycle(a, rnw, wd);
    finish_cycle(rdata, rready);
  endtask

  initial begin
    nRESET = 1'b0;
    Address_bus = 16'h0000;
    RnW = 1'b1;
    Data_in = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_out", 16'(Data_out), 16'h00);
    check("rst_ready", 16'(READY), 16'h1);
    check("rst_rom_req", 16'(rom_req), 16'h0);
    check("rst_rom_addr", 16'(rom_addr), 16'h0);
    check("rst_nirq", 16'(nIRQ), 16'h1);
    check("rst_state", 16'(rom_state), 16'h0);
    @(negedge clk);
    nRESET = 1'b1;
    finish_cycle(rd, rdy);

    // RAM write then read
    bus_cycle(16'h1234, 1'b0, 8'hA5, rd, rdy);
    start_cycle(16'h1234, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("ram_rd_latency", 16'(Data_out), 16'hA5);
    finish_cycle(rd, rdy);
    check("ram_rd_data", 16'(rd), 16'hA5);
    check("ram_rd_ready", 16'(rdy), 16'h1);
    bus_cycle(16'h7FFF, 1'b0, 8'h3C, rd, rdy);
    bus_cycle(16'h7FFF, 1'b1, 8'h00, rd, rdy);
    check("ram_top_data", 16'(rd), 16'h3C);

    // ROM write is ignored
    start_cycle(16'hC000, 1'b0, 8'h11);
    @(posedge clk);
    #1;
    check("rom_wr_no_req", 16'(rom_req), 16'h0);
    finish_cycle(rd, rdy);
    check("rom_wr_ready", 16'(rdy), 16'h1);

    // fast ROM ack: no wait-state
    ack_delay = 3;
    ack_data = 8'h00;
    start_cycle(16'hFFFC, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("rom_req_rise", 16'(rom_req), 16'h1);
    check("rom_addr", 16'(rom_addr), 16'h7FFC);
    check("ready_in_req", 16'(READY), 16'h0);
    check("rom_hold_prev", 16'(Data_out), 16'h3C);
    finish_cycle(rd, rdy);
    check("rom_fast_data", 16'(rd), 16'h00);
    check("rom_fast_ready", 16'(rdy), 16'h1);

    // slow ROM ack: one wait-state
    ack_delay = 20;
    ack_data = 8'h4C;
    bus_cycle(16'hC000, 1'b1, 8'h00, rd, rdy);
    check("rom_slow_wait", 16'(rdy), 16'h0);
    check("rom_slow_state", 16'(rom_state), 16'h1);
    bus_cycle(16'hC000, 1'b1, 8'h00, rd, rdy);
    check("rom_slow_ready", 16'(rdy), 16'h1);
    check("rom_slow_data", 16'(rd), 16'h4C);

    // no ack: timeout after 64 clocks gives four wait-states
    ack_delay = 0;
    waits = 0;
    rdy = 1'b0;
    while (!rdy && waits < 8) begin
      bus_cycle(16'hE000, 1'b1, 8'h00, rd, rdy);
      if (!rdy) waits++;
    end
    check("tmo_waits", 16'(waits), 16'd4);
    check("tmo_data", 16'(rd), 16'hFF);
    check("tmo_req_low", 16'(rom_req), 16'h0);
    bus_cycle(16'hFE00, 1'b1, 8'h00, rd, rdy);
    check("status_rom_err", 16'(rd), 16'h40);

    // I/O registers and timer
    bus_cycle(16'hFE00, 1'b0, 8'h40, rd, rdy);
    bus_cycle(16'hFE00, 1'b1, 8'h00, rd, rdy);
    check("status_cleared", 16'(rd), 16'h00);
    bus_cycle(16'hFE80, 1'b0, 8'h12, rd, rdy);
    bus_cycle(16'hFE80, 1'b1, 8'h00, rd, rdy);
    check("io_unused_ff", 16'(rd), 16'hFF);
    bus_cycle(16'hFE01, 1'b0, 8'h03, rd, rdy);
    bus_cycle(16'hFE01, 1'b1, 8'h00, rd, rdy);
    check("count_load", 16'(rd), 16'h03);
    bus_cycle(16'hFE00, 1'b0, 8'h03, rd, rdy);
    check("nirq_after_en", 16'(nIRQ), 16'h1);
    for (int k = 1; k <= 4; k++) begin
      bus_cycle(16'h1234, 1'b1, 8'h00, rd, rdy);
      check($sformatf("nirq_ce%0d", k), 16'(nIRQ), (k == 4) ? 16'h0 : 16'h1);
    end
    bus_cycle(16'hFE00, 1'b1, 8'h00, rd, rdy);
    check("status_irq", 16'(rd), 16'h83);
    check("nirq_cleared", 16'(nIRQ), 16'h1);
    bus_cycle(16'hFE01, 1'b1, 8'h00, rd, rdy);
    check("count_reloaded", 16'(rd), 16'h02);

    // asynchronous reset in the middle of a ROM request
    ack_delay = 0;
    ack_data = 8'h77;
    start_cycle(16'h9000, 1'b1, 8'h00);
    repeat (5) @(posedge clk);
    #1;
    check("mid_req", 16'(rom_req), 16'h1);
    @(negedge clk);
    nRESET = 1'b0;
    Address_bus = 16'h1234;
    #1;
    check("arst_rom_req", 16'(rom_req), 16'h0);
    check("arst_ready", 16'(READY), 16'h1);
    check("arst_state", 16'(rom_state), 16'h0);
    check("arst_data_out", 16'(Data_out), 16'h00);
    check("arst_nirq", 16'(nIRQ), 16'h1);
    repeat (2) @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack_state", 16'(rom_state), 16'h0);
    check("late_ack_data", 16'(Data_out), 16'hA5);
    check("late_ack_req", 16'(rom_req), 16'h0);
    finish_cycle(rd, rdy);
    bus_cycle(16'hFE00, 1'b1, 8'h00, rd, rdy);
    check("arst_status", 16'(rd), 16'h00);
    bus_cycle(16'hFE01, 1'b1, 8'h00, rd, rdy);
    check("arst_count", 16'(rd), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mos6502_bus_slave.md
# mos6502_bus_slave

Bus responder for the MOS6502 core: decodes the CPU's address/RnW each bus cycle and answers with read data, write capture and READY wait-states. It sits between the CPU and the memory system and contains internal 32 KiB RAM, a handshaked external ROM port with wait-state insertion and timeout, and a one-page I/O block holding a countdown timer that drives nIRQ.

## Interface
- TIMEOUT, 64: clocks allowed for rom_ack before the access is aborted (range 2..255).
- clk  in  1  system clock; one clock for the whole block.
- nRESET  in  1  asynchronous, active-low reset.
- clk_en  in  1  CPU cycle strobe, one clk wide, period 16 clk; a bus cycle ends on the clk edge where clk_en=1.
- Address_bus  in  16  CPU address, stable from the clk after clk_en until the next clk_en.
- RnW  in  1  1 = read, 0 = write.
- Data_in  in  8  CPU write data, valid at the clk_en edge.
- Data_out  out  8  registered read data.
- Data_oe  out  1  equals RnW; the top level uses it to drive the tristate Data_bus.
- READY  out  1  0 = CPU must repeat the cycle (wait-state).
- nIRQ  out  1  active-low timer interrupt.
- rom_addr  out  15  Address_bus[14:0] while rom_req=1.
- rom_req  out  1  ROM read request, level, held until rom_ack or timeout.
- rom_ack  in  1  one-clk pulse; rom_data valid in the same clk.
- rom_data  in  8  ROM read data.

## Operation
- Decode: RAM 0x0000–0x7FFF; IO 0xFE00–0xFEFF; ROM 0x8000–0xFFFF excluding the IO page.
- RAM read: Data_out <= ram[A[14:0]] on every clk (no wait). RAM write: ram[A] <= Data_in at the clk_en edge when RnW=0.
- ROM FSM states are IDLE, REQ and DONE.
  - IDLE→REQ on the first clk after clk_en when the address is ROM and RnW=1; rom_req=1 and the timeout counter is cleared.
  - REQ→DONE on rom_ack: Data_out <= rom_data and rom_req drops in the same edge.
  - REQ→DONE on reaching TIMEOUT clocks: Data_out <= 0xFF, status bit6 (rom_err) is set and rom_req drops.
  - DONE→IDLE on clk_en.
  - In DONE, Data_out is held and not overwritten by the RAM/IO path.
- READY = 0 only while the FSM is in REQ. The CPU repeats a cycle with the same address; a cycle that was answered (DONE) completes at the next clk_en.
- ROM writes are ignored: no request and READY stays 1.
- IO registers:
  - 0xFE00 write: ctrl[1:0] <= Data_in[1:0] (bit0 timer enable, bit1 irq enable). Data_in[7]=1 clears irq_flag; Data_in[6]=1 clears rom_err.
  - 0xFE00 read: {irq_flag, rom_err, 4'b0, ctrl[1:0]}. The completing clk_en of the read clears irq_flag.
  - 0xFE01 write: reload <= Data_in and count <= Data_in. Read returns count.
  - 0xFE02–0xFEFF: read 0xFF, writes ignored.
- Timer: when ctrl[0]=1, on each clk_en, count == 0 → count <= reload and irq_flag <= 1; otherwise count <= count-1. 8-bit and wraps via reload only.
- nIRQ = ~(irq_flag & ctrl[1]), registered.
- Simultaneous set and clear of irq_flag (underflow on the same clk_en as a status read or clear write): set wins.

## Timing
- Reset values: Data_out 0x00, READY 1, rom_req 0, rom_addr 0, nIRQ 1, ctrl 0, reload 0, count 0, irq_flag 0, rom_err 0, FSM IDLE. RAM contents are not reset.
- RAM and IO read latency is 1 clk after the address is stable; data is valid ≥14 clk before clk_en.
- ROM: rom_req rises 1 clk after the clk_en that starts the cycle.
- If rom_ack arrives ≤13 clk after rom_req rises, READY is never 0 at clk_en and there is no wait-state.
- Later acks produce one wait-state per clk_en spent in REQ.
- nRESET asserted mid-REQ: rom_req and READY return to reset values immediately (async). A late rom_ack afterwards is ignored.
- rom_ack in IDLE or DONE is ignored.

## Test plan
- Write 0xA5 to 0x1234, then read 0x1234 → Data_out=0xA5 one clk after the address, READY stays 1.
- Read 0xFFFC with rom_ack 3 clk after rom_req and rom_data=0x00 → no wait-state, Data_out=0x00 at clk_en, rom_addr=0x7FFC.
- Read 0xC000 with ack 20 clk after rom_req and data 0x4C → READY=0 at one clk_en, then cycle completes with 0x4C.
- No ack with TIMEOUT=64 → Data_out=0xFF, rom_err=1, and a read of 0xFE00 returns 0x40.
- Write 0x03 to 0xFE01 and 0x03 to 0xFE00 → nIRQ falls at the 4th clk_en. Reading 0xFE00 returns 0x83 and nIRQ returns to 1 after that read's clk_en.
- Pull nRESET low for 2 clk mid-REQ → rom_req=0, READY=1 asynchronously, and all registers return to reset values.
